// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, fetch constants, fetch FSM encoding
// and the fetch-buffer entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ILEN-1:0] NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        F_PEDIR     = 2'd0,
        F_ESPERAR   = 2'd1,
        F_DESCARTAR = 2'd2
    } fetch_st_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_ent_t;

endpackage

// File: rtl/buffer_instr.sv
// Two-entry {word, pc} FIFO in front of decode. Entry 0 is always the head,
// so the head outputs come straight from flops.
module buffer_instr
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_ent_t din,
    output fetch_ent_t head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    fetch_ent_t ent0_q, ent0_d;
    fetch_ent_t ent1_q, ent1_d;
    logic [1:0] count_q, count_d;
    logic       pop_ok;
    logic       push_ok;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        pop_ok  = pop && (count_q != 2'd0);
        push_ok = push && ((count_q != 2'd2) || pop_ok);
        // Flush wins over push and pop; the head is simply forgotten.
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = din;
                    else                 ent1_d = din;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = din;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign head  = ent0_q;
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: one outstanding memory request at a time, two-deep
// buffer to decode, redirect flushes buffered and in-flight instructions.
module etapa_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        salto,
    input  logic [31:0] pc_destino,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] instruccion,
    output logic [6:0]  opcode,
    output logic [31:0] pc_out,
    output logic        error_alin
);

    fetch_st_e   state_q, state_d;
    logic [31:0] pc_fetch_q, pc_fetch_d;
    logic [31:0] pc_req_q, pc_req_d;
    logic        error_alin_q, error_alin_d;
    logic        run_q;
    logic        push_c;
    logic [31:0] target_c;
    fetch_ent_t  head;
    logic [1:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    assign target_c = {pc_destino[31:2], 2'b00};

    // run_q keeps mem_req low until the first clock edge after reset release.
    assign mem_req  = run_q && (state_q == F_PEDIR) && (fifo_count < 2'd2);
    assign mem_addr = pc_fetch_q;

    always_comb begin
        state_d      = state_q;
        pc_fetch_d   = pc_fetch_q;
        pc_req_d     = pc_req_q;
        push_c       = 1'b0;
        error_alin_d = salto && (pc_destino[1:0] != 2'b00);
        case (state_q)
            F_PEDIR: begin
                if (salto) begin
                    pc_fetch_d = target_c;
                    if (mem_req && mem_gnt) state_d = F_DESCARTAR;
                end else if (mem_req && mem_gnt) begin
                    pc_req_d   = pc_fetch_q;
                    pc_fetch_d = pc_fetch_q + PC_INC;
                    state_d    = F_ESPERAR;
                end
            end
            F_ESPERAR: begin
                if (salto) begin
                    pc_fetch_d = target_c;
                    state_d    = mem_rvalid ? F_PEDIR : F_DESCARTAR;
                end else if (mem_rvalid) begin
                    push_c  = 1'b1;
                    state_d = F_PEDIR;
                end
            end
            F_DESCARTAR: begin
                if (salto) pc_fetch_d = target_c;
                if (mem_rvalid) state_d = F_PEDIR;
            end
            default: state_d = F_PEDIR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= F_PEDIR;
            pc_fetch_q   <= PC_RESET;
            pc_req_q     <= PC_RESET;
            error_alin_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_fetch_q   <= pc_fetch_d;
            pc_req_q     <= pc_req_d;
            error_alin_q <= error_alin_d;
            run_q        <= 1'b1;
        end
    end

    buffer_instr u_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c && !fifo_full),
        .pop   (dec_valid && dec_ready),
        .flush (salto),
        .din   ({mem_rdata, pc_req_q}),
        .head  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign dec_valid   = !fifo_empty;
    assign instruccion = head.instr;
    assign opcode      = head.instr[6:0];
    assign pc_out      = head.pc;
    assign error_alin  = error_alin_q;

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed bench for etapa_fetch with a one-outstanding-request memory model.
module tb_etapa_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        salto = 1'b0;
    logic [31:0] pc_destino = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] instruccion;
    logic [6:0]  opcode;
    logic [31:0] pc_out;
    logic        error_alin;

    int          checks = 0;
    int          errors = 0;
    logic        pend = 1'b0;
    int          wcnt = 0;
    int          lat = 1;
    logic [31:0] paddr = 32'h0;
    logic [31:0] got[$];
    logic [31:0] issued[$];

    always #5 clk = ~clk;

    etapa_fetch #(.PC_RESET(32'h0000_0100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .salto       (salto),
        .pc_destino  (pc_destino),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .instruccion (instruccion),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .error_alin  (error_alin)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    // One clock: record delivery/grant, advance, then drive memory for the new cycle.
    task automatic tick();
        logic        granted;
        logic [31:0] a;
        logic [31:0] w;
        granted = mem_req && mem_gnt;
        a       = mem_addr;
        if (dec_valid && dec_ready && !salto) begin
            w = word_of(pc_out);
            chk_eq("mon_instr", instruccion, w);
            chk_eq("mon_opcode", 32'(opcode), 32'(w[6:0]));
            got.push_back(pc_out);
        end
        if (granted) issued.push_back(a);
        @(posedge clk);
        #1;
        salto = 1'b0;
        if (granted) begin
            pend  = 1'b1;
            wcnt  = lat;
            paddr = a;
        end
        mem_rvalid = 1'b0;
        if (pend) begin
            wcnt--;
            if (wcnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = word_of(paddr);
                pend       = 1'b0;
            end
        end
        mem_gnt = mem_req;
    endtask

    task automatic do_reset();
        rst_n      = 1'b1;
        #1;
        rst_n      = 1'b0;
        salto      = 1'b0;
        pc_destino = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        pend       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got.delete();
        issued.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and sequential fetch at one instruction per two cycles.
        lat       = 1;
        dec_ready = 1'b1;
        rst_n     = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_req", 32'(mem_req), 32'd0);
        chk_eq("rst_addr", mem_addr, 32'h100);
        chk_eq("rst_valid", 32'(dec_valid), 32'd0);
        chk_eq("rst_instr", instruccion, 32'h0);
        chk_eq("rst_opcode", 32'(opcode), 32'd0);
        chk_eq("rst_pc", pc_out, 32'h0);
        chk_eq("rst_err", 32'(error_alin), 32'd0);
        rst_n = 1'b1;
        tick();
        chk_eq("t1_a_req", 32'(mem_req), 32'd1);
        chk_eq("t1_a_addr", mem_addr, 32'h100);
        tick();
        chk_eq("t1_b_req", 32'(mem_req), 32'd0);
        chk_eq("t1_b_valid", 32'(dec_valid), 32'd0);
        tick();
        chk_eq("t1_c_valid", 32'(dec_valid), 32'd1);
        chk_eq("t1_c_pc", pc_out, 32'h100);
        chk_eq("t1_c_instr", instruccion, 32'h5A5A_0113);
        chk_eq("t1_c_opcode", 32'(opcode), 32'h13);
        chk_eq("t1_c_addr", mem_addr, 32'h104);
        tick();
        chk_eq("t1_d_valid", 32'(dec_valid), 32'd0);
        tick();
        chk_eq("t1_e_pc", pc_out, 32'h104);
        chk_eq("t1_e_addr", mem_addr, 32'h108);
        tick();
        chk_eq("t1_f_valid", 32'(dec_valid), 32'd0);
        tick();
        chk_eq("t1_g_pc", pc_out, 32'h108);
        chk_eq("t1_g_addr", mem_addr, 32'h10C);

        // Decode stalled: two requests fill the buffer, head holds.
        dec_ready = 1'b0;
        lat       = 1;
        do_reset();
        repeat (10) tick();
        chk_eq("t2_nreq", 32'(issued.size()), 32'd2);
        chk_eq("t2_req0", q_at(issued, 0), 32'h100);
        chk_eq("t2_req1", q_at(issued, 1), 32'h104);
        chk_eq("t2_req_low", 32'(mem_req), 32'd0);
        chk_eq("t2_valid", 32'(dec_valid), 32'd1);
        chk_eq("t2_head_pc", pc_out, 32'h100);
        chk_eq("t2_head_instr", instruccion, 32'h5A5A_0113);
        dec_ready = 1'b1;
        repeat (12) tick();
        chk_eq("t2_del0", q_at(got, 0), 32'h100);
        chk_eq("t2_del1", q_at(got, 1), 32'h104);
        chk_eq("t2_del2", q_at(got, 2), 32'h108);
        chk_eq("t2_del3", q_at(got, 3), 32'h10C);

        // Redirect in ESPERAR with a late response and a non-empty buffer.
        dec_ready = 1'b0;
        lat       = 1;
        do_reset();
        repeat (3) tick();
        lat = 4;
        tick();
        chk_eq("t3_d_valid", 32'(dec_valid), 32'd1);
        salto      = 1'b1;
        pc_destino = 32'h200;
        tick();
        chk_eq("t3_e_valid", 32'(dec_valid), 32'd0);
        chk_eq("t3_e_req", 32'(mem_req), 32'd0);
        chk_eq("t3_e_err", 32'(error_alin), 32'd0);
        tick();
        chk_eq("t3_f_req", 32'(mem_req), 32'd0);
        tick();
        chk_eq("t3_g_req", 32'(mem_req), 32'd0);
        tick();
        chk_eq("t3_h_req", 32'(mem_req), 32'd1);
        chk_eq("t3_h_addr", mem_addr, 32'h200);
        lat       = 1;
        dec_ready = 1'b1;
        repeat (8) tick();
        chk_eq("t3_del0", q_at(got, 0), 32'h200);
        chk_eq("t3_del1", q_at(got, 1), 32'h204);

        // Redirect in the same cycle as a grant: that response is stale.
        dec_ready = 1'b1;
        lat       = 1;
        do_reset();
        tick();
        chk_eq("t4_a_req", 32'(mem_req), 32'd1);
        salto      = 1'b1;
        pc_destino = 32'h400;
        tick();
        chk_eq("t4_b_req", 32'(mem_req), 32'd0);
        chk_eq("t4_b_valid", 32'(dec_valid), 32'd0);
        tick();
        chk_eq("t4_c_req", 32'(mem_req), 32'd1);
        chk_eq("t4_c_addr", mem_addr, 32'h400);
        repeat (6) tick();
        chk_eq("t4_del0", q_at(got, 0), 32'h400);

        // Misaligned target: one-cycle error pulse, fetch at the aligned address.
        got.delete();
        salto      = 1'b1;
        pc_destino = 32'h203;
        tick();
        chk_eq("t5_err_hi", 32'(error_alin), 32'd1);
        chk_eq("t5_valid", 32'(dec_valid), 32'd0);
        tick();
        chk_eq("t5_err_lo", 32'(error_alin), 32'd0);
        repeat (8) tick();
        chk_eq("t5_del0", q_at(got, 0), 32'h200);

        // PC wraps modulo 2^32.
        salto      = 1'b1;
        pc_destino = 32'hFFFF_FFFC;
        tick();
        issued.delete();
        got.delete();
        repeat (10) tick();
        chk_eq("t6_req0", q_at(issued, 0), 32'hFFFF_FFFC);
        chk_eq("t6_req1", q_at(issued, 1), 32'h0000_0000);
        chk_eq("t6_del0", q_at(got, 0), 32'hFFFF_FFFC);
        chk_eq("t6_del1", q_at(got, 1), 32'h0000_0000);

        // Asynchronous reset while waiting for a response.
        dec_ready = 1'b0;
        lat       = 1;
        do_reset();
        repeat (3) tick();
        lat = 3;
        tick();
        chk_eq("t7_pre_req", 32'(mem_req), 32'd0);
        chk_eq("t7_pre_valid", 32'(dec_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk_eq("t7_req", 32'(mem_req), 32'd0);
        chk_eq("t7_addr", mem_addr, 32'h100);
        chk_eq("t7_valid", 32'(dec_valid), 32'd0);
        chk_eq("t7_instr", instruccion, 32'h0);
        chk_eq("t7_opcode", 32'(opcode), 32'd0);
        chk_eq("t7_pc", pc_out, 32'h0);
        chk_eq("t7_err", 32'(error_alin), 32'd0);
        pend       = 1'b0;
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/etapa_fetch.md
# etapa_fetch

Instruction-fetch stage of the RISC-V core, directly upstream of decode/`ImmGen`. It holds the fetch PC, fetches instructions one at a time from instruction memory over a request/grant/response handshake, and buffers up to two fetched words in front of decode with a valid/ready handshake. A branch/jump redirect from execute flushes buffered and in-flight instructions and restarts fetch at the target.

## Interface

- `PC_RESET`, default 32'h0000_0000, fetch address after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  32  fetch address, word-aligned.
- `mem_gnt`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  instruction word.
- `salto`  in  1  redirect pulse (taken branch or jump).
- `pc_destino`  in  32  redirect target, sampled when `salto`=1.
- `dec_valid`  out  1  buffer head is valid.
- `dec_ready`  in  1  decode consumes the head this cycle.
- `instruccion`  out  32  head instruction word, fed to `ImmGen.instruccion`.
- `opcode`  out  7  equals `instruccion[6:0]`, fed to `ImmGen.opcode`.
- `pc_out`  out  32  address of the head instruction.
- `error_alin`  out  1  one-cycle pulse: the last `pc_destino` had bits [1:0] ≠ 0.

## Operation

- Registers: `pc_fetch`, `pc_req` (address of the outstanding request), FSM state, and a 2-entry FIFO of {word, pc}.
- There is at most one outstanding memory request. Peak throughput is one instruction per 2 cycles.
- **PEDIR**:
  - `mem_req` = (count < 2), with `mem_addr` = `pc_fetch`.
  - `mem_req & mem_gnt` and no `salto`: `pc_req` <= `pc_fetch`, `pc_fetch` += 4, go to ESPERAR.
  - `salto` with no grant: `pc_fetch` <= target, stay in PEDIR. `mem_addr` may change before grant; memory latches nothing without `mem_gnt`.
  - `salto` and grant in the same cycle: the granted request is stale. `pc_fetch` <= target, go to DESCARTAR.
- **ESPERAR**: `mem_req`=0.
  - `mem_rvalid` and no `salto`: push {`mem_rdata`, `pc_req`}, go to PEDIR.
  - `salto` and no `mem_rvalid`: go to DESCARTAR.
  - `salto` and `mem_rvalid`: drop the data, go to PEDIR.
  - In every `salto` case, `pc_fetch` <= target.
- **DESCARTAR**: `mem_req`=0.
  - `mem_rvalid`: drop the data, go to PEDIR.
  - `salto`: `pc_fetch` <= target. A `salto` here may coincide with `mem_rvalid`.
- Redirect target is {`pc_destino[31:2]`, 2'b00}. `error_alin` is registered and goes high the cycle after a `salto` whose `pc_destino[1:0]` ≠ 0.
- FIFO:
  - Pop on `dec_valid & dec_ready`. Push and pop in the same cycle leave count unchanged.
  - `salto` clears the FIFO. It has priority over push and pop in the same cycle, and the head is not counted as consumed.
  - A push never occurs at count=2: requests are issued only with count < 2, and nothing else fills the FIFO.
- While `dec_valid`=1 and `dec_ready`=0, `instruccion`, `opcode` and `pc_out` hold stable.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing

- Reset values: FSM in PEDIR, `pc_fetch` = `PC_RESET`, count = 0.
  - Outputs: `mem_req`=0, `mem_addr`=`PC_RESET`, `dec_valid`=0, `instruccion`=0, `opcode`=0, `pc_out`=0, `error_alin`=0.
- `mem_req`/`mem_addr` are combinational from state, count and `pc_fetch`. `mem_req` rises in the first cycle after `rst_n` deassertion.
- `mem_rvalid` in cycle N gives `dec_valid`=1 in cycle N+1.
- `salto` in cycle N gives `dec_valid`=0 in cycle N+1. The next `mem_req` carries the target in cycle N+1, or later if a stale response is still pending.
- Reset mid-operation clears everything immediately. A memory response arriving after reset while in PEDIR is a protocol violation by memory and is ignored.

## Structure

- Shared package `riscv_pkg`:
  - opcode constants (LUI 0110111, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111);
  - `NOP` = 32'h0000_0013;
  - `PC_INC` = 4;
  - fetch FSM state encoding.
- Sub-module `buffer_instr`: 2-entry FIFO, 64 bits wide, with push, pop and synchronous flush, exposing count/full/empty.

## Test plan

- Reset with `PC_RESET`=32'h100; memory grants immediately, rvalid 1 cycle later, `dec_ready`=1 -> `mem_addr` sequence 0x100, 0x104, 0x108; `pc_out` matches each word; one instruction per 2 cycles.
- Hold `dec_ready`=0 -> exactly two requests issued, then `mem_req`=0; head holds 0x100/word0. Release `dec_ready` -> words delivered in order with no loss.
- `salto` with `pc_destino`=0x200 while in ESPERAR; the response arrives 3 cycles later -> that word is dropped; next request is 0x200; FIFO empty in the cycle after `salto`.
- `salto` in the same cycle as `mem_gnt` -> the response for the old address is discarded; first delivered `pc_out` = target.
- `pc_destino`=0x203 -> `error_alin` pulses for one cycle; fetch resumes at 0x200.
- `pc_fetch`=0xFFFF_FFFC -> the following request is at 0x0000_0000. Assert `rst_n`=0 mid-ESPERAR -> all outputs return to their reset values asynchronously.
